burst_ram_arbiter: RTL and testbench

//   Two-master arbiter in front of the single BurstRAM port. Lets an instruction-side and
//   a data-side Cache share one burst RAM. Sits between the Cache br_* ports (upstream)
//   and BurstRAM (downstream). Grants whole bursts, round-robin, and never splits a burst.

---
 rtl/burst_ram_pkg.sv | 16 +
 rtl/burst_ram_mux.sv | 36 +++
 rtl/burst_ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM arbiter.
//   arb_state_t : arbiter FSM states
//   CMD_READ / CMD_WRITE : encoding of the br_cmd / mN_cmd bit
package burst_ram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        WRITE   = 2'd2,
        READ    = 2'd3
    } arb_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_mux.sv
// Owner select of the BurstRAM request signals.
//   owner      : 0 selects master 0, 1 selects master 1
//   cmd_allow  : high only while a command may start (arbiter in GRANTED)
//   mN_*       : request-side signals of both masters
//   br_*       : request-side signals towards BurstRAM
// Purely combinational; the non-owner's cmd_en can never reach the RAM.
module burst_ram_mux #(
    parameter int AddressBitWidth = 4,
    parameter int DataBitWidth    = 64
) (
    input  logic                       owner,
    input  logic                       cmd_allow,
    input  logic                       m0_cmd,
    input  logic                       m0_cmd_en,
    input  logic [AddressBitWidth-1:0] m0_addr,
    input  logic [DataBitWidth-1:0]    m0_wr_data,
    input  logic [7:0]                 m0_data_mask,
    input  logic                       m1_cmd,
    input  logic                       m1_cmd_en,
    input  logic [AddressBitWidth-1:0] m1_addr,
    input  logic [DataBitWidth-1:0]    m1_wr_data,
    input  logic [7:0]                 m1_data_mask,
    output logic                       br_cmd,
    output logic                       br_cmd_en,
    output logic [AddressBitWidth-1:0] br_addr,
    output logic [DataBitWidth-1:0]    br_wr_data,
    output logic [7:0]                 br_data_mask
);

    assign br_cmd       = owner ? m1_cmd       : m0_cmd;
    assign br_addr      = owner ? m1_addr      : m0_addr;
    assign br_wr_data   = owner ? m1_wr_data   : m0_wr_data;
    assign br_data_mask = owner ? m1_data_mask : m0_data_mask;
    assign br_cmd_en    = cmd_allow & (owner ? m1_cmd_en : m0_cmd_en);

endmodule

// File: rtl/burst_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single BurstRAM port.
// Grants whole bursts and never splits one.
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0_* / m1_*         : cache-side burst ports (req/gnt handshake, cmd, data)
//   mN_rd_data          : br_rd_data broadcast to both masters
//   mN_rd_data_valid    : br_rd_data_valid, only towards the owner of a read burst
//   br_*                : BurstRAM-side port
module burst_ram_arbiter
    import burst_ram_pkg::*;
#(
    parameter int AddressBitWidth = 4,
    parameter int BurstDataCount  = 4,
    parameter int DataBitWidth    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m0_req,
    output logic                       m0_gnt,
    input  logic                       m0_cmd,
    input  logic                       m0_cmd_en,
    input  logic [AddressBitWidth-1:0] m0_addr,
    input  logic [DataBitWidth-1:0]    m0_wr_data,
    input  logic [7:0]                 m0_data_mask,
    output logic [DataBitWidth-1:0]    m0_rd_data,
    output logic                       m0_rd_data_valid,
    input  logic                       m1_req,
    output logic                       m1_gnt,
    input  logic                       m1_cmd,
    input  logic                       m1_cmd_en,
    input  logic [AddressBitWidth-1:0] m1_addr,
    input  logic [DataBitWidth-1:0]    m1_wr_data,
    input  logic [7:0]                 m1_data_mask,
    output logic [DataBitWidth-1:0]    m1_rd_data,
    output logic                       m1_rd_data_valid,
    output logic                       br_cmd,
    output logic                       br_cmd_en,
    output logic [AddressBitWidth-1:0] br_addr,
    output logic [DataBitWidth-1:0]    br_wr_data,
    output logic [7:0]                 br_data_mask,
    input  logic [DataBitWidth-1:0]    br_rd_data,
    input  logic                       br_rd_data_valid,
    input  logic                       br_busy
);

    localparam int              CntWidth = $clog2(BurstDataCount) + 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BurstDataCount - 1);

    arb_state_t          state;
    logic                owner;
    logic                last_owner;
    logic [CntWidth-1:0] beat_cnt;

    logic own_req;
    logic next_owner;

    assign own_req = owner ? m1_req : m0_req;

    // Round robin: on a tie the master that did not own the last burst wins.
    assign next_owner = (m0_req && m1_req) ? ~last_owner : m1_req;

    burst_ram_mux #(
        .AddressBitWidth(AddressBitWidth),
        .DataBitWidth   (DataBitWidth)
    ) u_mux (
        .owner       (owner),
        .cmd_allow   (state == GRANTED),
        .m0_cmd      (m0_cmd),
        .m0_cmd_en   (m0_cmd_en),
        .m0_addr     (m0_addr),
        .m0_wr_data  (m0_wr_data),
        .m0_data_mask(m0_data_mask),
        .m1_cmd      (m1_cmd),
        .m1_cmd_en   (m1_cmd_en),
        .m1_addr     (m1_addr),
        .m1_wr_data  (m1_wr_data),
        .m1_data_mask(m1_data_mask),
        .br_cmd      (br_cmd),
        .br_cmd_en   (br_cmd_en),
        .br_addr     (br_addr),
        .br_wr_data  (br_wr_data),
        .br_data_mask(br_data_mask)
    );

    // Read data is broadcast; only the valid strobe is steered, and only in READ.
    assign m0_rd_data       = br_rd_data;
    assign m1_rd_data       = br_rd_data;
    assign m0_rd_data_valid = br_rd_data_valid && (state == READ) && !owner;
    assign m1_rd_data_valid = br_rd_data_valid && (state == READ) &&  owner;

    // NOTE: state and grants are updated with non-blocking assignments so every
    // branch below sees the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!br_busy && (m0_req || m1_req)) begin
                        owner  <= next_owner;
                        m0_gnt <= !next_owner;
                        m1_gnt <=  next_owner;
                        state  <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (br_cmd_en) begin
                        // The command cycle already carries write beat 0.
                        if (br_cmd == CMD_WRITE) begin
                            state    <= WRITE;
                            beat_cnt <= CntWidth'(1);
                        end else begin
                            state    <= READ;
                            beat_cnt <= '0;
                        end
                    end else if (!own_req) begin
                        state      <= IDLE;
                        m0_gnt     <= 1'b0;
                        m1_gnt     <= 1'b0;
                        last_owner <= owner;
                    end
                end
                WRITE: begin
                    beat_cnt <= beat_cnt + CntWidth'(1);
                    if (beat_cnt >= LastBeat) begin
                        state      <= IDLE;
                        m0_gnt     <= 1'b0;
                        m1_gnt     <= 1'b0;
                        last_owner <= owner;
                    end
                end
                READ: begin
                    if (br_rd_data_valid) begin
                        beat_cnt <= beat_cnt + CntWidth'(1);
                        if (beat_cnt == LastBeat) begin
                            state      <= IDLE;
                            m0_gnt     <= 1'b0;
                            m1_gnt     <= 1'b0;
                            last_owner <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter with a behavioural BurstRAM
// (4-beat bursts, read data after a fixed latency, preloaded contents).
module tb_burst_ram_arbiter;
    import burst_ram_pkg::*;

    localparam int AW  = 4;
    localparam int BDC = 4;
    localparam int DW  = 64;
    localparam int LAT = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req    [2];
    logic          cmd    [2];
    logic          cmd_en [2];
    logic [AW-1:0] addr   [2];
    logic [DW-1:0] wr     [2];
    logic [7:0]    mask   [2];

    logic          gnt0, gnt1, rdv0, rdv1;
    logic [DW-1:0] rd0, rd1;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data, br_rd_data;
    logic [7:0]    br_data_mask;
    logic          model_valid, stray, busy;
    logic          br_rd_data_valid;

    assign br_rd_data_valid = model_valid | stray;

    burst_ram_arbiter #(
        .AddressBitWidth(AW),
        .BurstDataCount (BDC),
        .DataBitWidth   (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_req          (req[0]),
        .m0_gnt          (gnt0),
        .m0_cmd          (cmd[0]),
        .m0_cmd_en       (cmd_en[0]),
        .m0_addr         (addr[0]),
        .m0_wr_data      (wr[0]),
        .m0_data_mask    (mask[0]),
        .m0_rd_data      (rd0),
        .m0_rd_data_valid(rdv0),
        .m1_req          (req[1]),
        .m1_gnt          (gnt1),
        .m1_cmd          (cmd[1]),
        .m1_cmd_en       (cmd_en[1]),
        .m1_addr         (addr[1]),
        .m1_wr_data      (wr[1]),
        .m1_data_mask    (mask[1]),
        .m1_rd_data      (rd1),
        .m1_rd_data_valid(rdv1),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy         (busy)
    );

    function automatic logic [DW-1:0] preload(input int i);
        return 64'hC0DE_0000_0000_0000 | DW'(i * 16'h0101);
    endfunction

    // ---------------- BurstRAM model ----------------
    logic [DW-1:0] mem [16];
    logic          mem_loaded = 1'b0;
    logic [AW-1:0] wptr, rptr;
    int            wleft, rleft, rwait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_valid <= 1'b0;
            br_rd_data  <= '0;
            wleft       <= 0;
            rleft       <= 0;
            rwait       <= 0;
            if (!mem_loaded) begin
                for (int i = 0; i < 16; i++) mem[i] <= preload(i);
                mem_loaded <= 1'b1;
            end
        end else begin
            model_valid <= 1'b0;
            if (br_cmd_en && br_cmd) begin
                mem[br_addr] <= br_wr_data;
                wptr         <= br_addr + AW'(1);
                wleft        <= BDC - 1;
            end else if (wleft > 0) begin
                mem[wptr] <= br_wr_data;
                wptr      <= wptr + AW'(1);
                wleft     <= wleft - 1;
            end
            if (br_cmd_en && !br_cmd) begin
                rptr  <= br_addr;
                rwait <= LAT - 1;
                rleft <= BDC;
            end else if (rwait > 0) begin
                rwait <= rwait - 1;
            end else if (rleft > 0) begin
                model_valid <= 1'b1;
                br_rd_data  <= mem[rptr];
                rptr        <= rptr + AW'(1);
                rleft       <= rleft - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic          m;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] shadow [16];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            beats_seen = 0;
    bit            pend_fall = 0;
    bit            pend_m = 0;
    bit            flag;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read beats are popped and compared as they appear at the masters.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pend_fall) begin
                    pend_fall = 0;
                    check("rd_gnt_fall", DW'(pend_m ? gnt1 : gnt0), '0);
                end
                for (int m = 0; m < 2; m++) begin
                    if ((m == 0) ? rdv0 : rdv1) begin
                        if (q.size() == 0) begin
                            check($sformatf("unexpected_valid_m%0d", m), DW'((m == 0) ? rdv0 : rdv1), '0);
                        end else begin
                            e = q.pop_front();
                            check("rd_owner", DW'(m), DW'(e.m));
                            check("rd_data", (m == 0) ? rd0 : rd1, e.data);
                            beats_seen++;
                            if (e.last) begin
                                pend_fall = 1;
                                pend_m    = e.m;
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? gnt0 : gnt1;
    endfunction

    task automatic do_burst(input int m, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] wbase);
        logic [AW-1:0] ai;
        exp_t          e;
        if (c == CMD_READ) begin
            for (int i = 0; i < BDC; i++) begin
                ai     = a + AW'(i);
                e.m    = 1'(m);
                e.last = (i == BDC - 1);
                e.data = shadow[ai];
                q.push_back(e);
            end
        end else begin
            shadow[a] = wbase;
        end
        cmd[m]    = c;
        cmd_en[m] = 1'b1;
        addr[m]   = a;
        wr[m]     = wbase;
        tick();
        cmd_en[m] = 1'b0;
        req[m]    = 1'b0;
        if (c == CMD_WRITE) begin
            for (int i = 1; i < BDC; i++) begin
                ai         = a + AW'(i);
                wr[m]      = wbase * DW'(i + 1);
                shadow[ai] = wr[m];
                tick();
            end
            check("wr_gnt_fall", DW'(gnt_of(m)), '0);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (!gnt0 && !gnt1) done = 1;
            else tick();
        end
        if (!done) check("idle_timeout", DW'({gnt0, gnt1}), '0);
    endtask

    typedef struct {
        logic          r0;
        logic          r1;
        int            win;
        logic          c;
        logic [AW-1:0] a;
        logic [DW-1:0] wbase;
    } row_t;

    row_t rows [6];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int b0;
        rows[0] = '{r0: 1'b1, r1: 1'b1, win: 1, c: CMD_WRITE, a: 4'd8,  wbase: 64'h1111_1111_1111_1111};
        rows[1] = '{r0: 1'b1, r1: 1'b1, win: 0, c: CMD_READ,  a: 4'd8,  wbase: '0};
        rows[2] = '{r0: 1'b1, r1: 1'b0, win: 0, c: CMD_READ,  a: 4'd2,  wbase: '0};
        rows[3] = '{r0: 1'b1, r1: 1'b1, win: 1, c: CMD_WRITE, a: 4'd12, wbase: 64'h0101_0101_0101_0101};
        rows[4] = '{r0: 1'b1, r1: 1'b1, win: 0, c: CMD_READ,  a: 4'd12, wbase: '0};
        rows[5] = '{r0: 1'b0, r1: 1'b1, win: 1, c: CMD_READ,  a: 4'd0,  wbase: '0};

        for (int i = 0; i < 16; i++) shadow[i] = preload(i);
        for (int m = 0; m < 2; m++) begin
            req[m] = 0; cmd[m] = 0; cmd_en[m] = 0; addr[m] = '0; wr[m] = '0;
        end
        mask[0] = 8'h5A;
        mask[1] = 8'hC3;
        stray = 0;
        busy  = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt0", DW'(gnt0), '0);
        check("rst_gnt1", DW'(gnt1), '0);
        check("rst_br_cmd_en", DW'(br_cmd_en), '0);
        rst_n = 1'b1;
        tick();

        // Simultaneous requests after reset: m0 first, then m1, then m0 again
        req[0] = 1; req[1] = 1;
        tick();
        check("rr_first_gnt0", DW'(gnt0), DW'(1));
        check("rr_first_gnt1", DW'(gnt1), '0);
        do_burst(0, CMD_READ, 4'd2, '0);
        flag = 0;
        for (int i = 0; i < 80 && !flag; i++) begin
            tick();
            flag = !gnt0;
        end
        tick();
        check("rr_second_gnt1", DW'(gnt1), DW'(1));
        check("rr_second_gnt0", DW'(gnt0), '0);
        do_burst(1, CMD_READ, 4'd3, '0);
        wait_idle();
        req[0] = 1; req[1] = 1;
        tick();
        check("rr_third_gnt0", DW'(gnt0), DW'(1));
        req[0] = 0; req[1] = 0;
        tick();
        check("drop_req_gnt0", DW'(gnt0), '0);

        // Table-driven arbitration and bursts
        for (int r = 0; r < 6; r++) begin
            req[0] = rows[r].r0;
            req[1] = rows[r].r1;
            tick();
            check($sformatf("row%0d_gnt0", r), DW'(gnt0), DW'(rows[r].win == 0));
            check($sformatf("row%0d_gnt1", r), DW'(gnt1), DW'(rows[r].win == 1));
            req[1 - rows[r].win] = 0;
            do_burst(rows[r].win, rows[r].c, rows[r].a, rows[r].wbase);
            wait_idle();
        end

        // Non-owner cmd_en must not reach the RAM
        req[1] = 1;
        tick();
        check("x_gnt1", DW'(gnt1), DW'(1));
        cmd[0] = CMD_WRITE; addr[0] = 4'd8; wr[0] = '1; cmd_en[0] = 1; stray = 1;
        #1;
        check("x_br_cmd_en_a", DW'(br_cmd_en), '0);
        check("x_br_mask", DW'(br_data_mask), DW'(8'hC3));
        tick();
        check("x_br_cmd_en_b", DW'(br_cmd_en), '0);
        check("x_gnt1_hold", DW'(gnt1), DW'(1));
        cmd_en[0] = 0; stray = 0;
        do_burst(1, CMD_READ, 4'd8, '0);
        wait_idle();

        // Stray valid while idle
        stray = 1;
        @(negedge clk);
        check("stray_rdv0", DW'(rdv0), '0);
        check("stray_rdv1", DW'(rdv1), '0);
        tick();
        stray = 0;

        // No grant while BurstRAM is busy
        busy = 1; req[0] = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("busy_gnt0_c%0d", i), DW'(gnt0), '0);
        end
        busy = 0;
        tick();
        check("busy_release_gnt0", DW'(gnt0), DW'(1));
        req[0] = 0;
        tick();
        check("busy_drop_gnt0", DW'(gnt0), '0);

        // Reset in the middle of a read burst
        req[0] = 1;
        tick();
        check("mid_gnt0", DW'(gnt0), DW'(1));
        b0 = beats_seen;
        do_burst(0, CMD_READ, 4'd0, '0);
        flag = 0;
        for (int i = 0; i < 40 && !flag; i++) begin
            tick();
            flag = (beats_seen >= b0 + 2);
        end
        if (!flag) check("mid_beat_timeout", DW'(beats_seen - b0), DW'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt0", DW'(gnt0), '0);
        check("mid_rst_gnt1", DW'(gnt1), '0);
        check("mid_rst_br_cmd_en", DW'(br_cmd_en), '0);
        q.delete();
        pend_fall = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req[0] = 1; req[1] = 1;
        tick();
        check("post_rst_gnt0", DW'(gnt0), DW'(1));
        check("post_rst_gnt1", DW'(gnt1), '0);
        req[1] = 0;
        do_burst(0, CMD_READ, 4'd5, '0);
        wait_idle();
        tick();
        check("queue_drained", DW'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
